// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and opcode classification for alu_seq.
//   alu_op_e      4-bit opcode encoding (1110/1111 are unassigned -> illegal)
//   alu_state_e   sequencer states
//   is_multicycle opcode needs the iterative mul/div unit
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SLL  = 4'b0000,
    OP_SRL  = 4'b0001,
    OP_SRA  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_EQ   = 4'b1001,
    OP_NE   = 4'b1010,
    OP_MUL  = 4'b1011,
    OP_DIVU = 4'b1100,
    OP_REMU = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative multiply (shift-add) and unsigned divide/remainder
// (restoring), one iteration per cycle, WIDTH iterations per operation.
//   clk, rst     clock, synchronous active-high reset (aborts any operation)
//   start        latch a, b, op and begin iterating
//   op           OP_MUL, OP_DIVU or OP_REMU
//   a, b         operands (a = multiplicand/dividend, b = multiplier/divisor)
//   done         high during the final iteration cycle
//   result       final value, valid while done is high
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // Registers are shared between the two algorithms:
  //   x: product accumulator  / partial remainder
  //   y: multiplier (>>)      / dividend shifting out, quotient shifting in
  //   z: multiplicand (<<)    / divisor
  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] x_d, y_d, z_d;
  logic [WIDTH:0]   trial;

  always_comb begin
    trial = {x_q, y_q[WIDTH-1]} - {1'b0, z_q};
    x_d   = x_q;
    y_d   = y_q;
    z_d   = z_q;
    if (op_q == OP_MUL) begin
      x_d = x_q + (y_q[0] ? z_q : '0);
      y_d = y_q >> 1;
      z_d = z_q << 1;
    end else if (!trial[WIDTH]) begin
      // A zero divisor never borrows: quotient fills with ones and the
      // remainder collects the dividend unchanged.
      x_d = trial[WIDTH-1:0];
      y_d = {y_q[WIDTH-2:0], 1'b1};
    end else begin
      x_d = {x_q[WIDTH-2:0], y_q[WIDTH-1]};
      y_d = {y_q[WIDTH-2:0], 1'b0};
    end
  end

  // Result is taken from the next-state values so it is usable in the same
  // cycle as the last iteration.
  assign done   = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign result = (op_q == OP_DIVU) ? y_d : x_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_MUL;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      op_q   <= op;
      x_q    <= '0;
      y_q    <= (op == OP_MUL) ? b : a;
      z_q    <= (op == OP_MUL) ? a : b;
    end else if (busy_q) begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU between issue and writeback. Single-cycle ops
// (shifts, add/sub, logic, compares) have 1-cycle latency; MUL/DIVU/REMU
// iterate for WIDTH cycles in alu_muldiv_iter.
// Build option: define ALU_SEQ_MULDIV_EN to include MUL/DIVU/REMU; without
// it those opcodes are illegal (1-cycle, result 0, alu_err=1).
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operation handshake (alu_op, op1, op2)
//   out_valid/out_ready      result handshake (alu_result, alu_err)
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_err
);

  alu_state_e       state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result_d;
  logic             sc_err_d;

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign alu_err    = err_q;
  assign shamt      = op2[SHW-1:0];

  // DONE forwards out_ready so a new op can replace the held result in the
  // same cycle it is consumed.
  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Multicycle opcodes land in the default arm; with the mul/div unit built
  // they are steered to BUSY before this result is ever used.
  always_comb begin
    sc_result_d = '0;
    sc_err_d    = 1'b0;
    case (alu_op)
      OP_SLL: sc_result_d = op1 << shamt;
      OP_SRL: sc_result_d = op1 >> shamt;
      OP_SRA: sc_result_d = $unsigned($signed(op1) >>> shamt);
      OP_ADD: sc_result_d = op1 + op2;
      OP_SUB: sc_result_d = op1 - op2;
      OP_AND: sc_result_d = op1 & op2;
      OP_OR:  sc_result_d = op1 | op2;
      OP_XOR: sc_result_d = op1 ^ op2;
      OP_SLT: sc_result_d = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OP_EQ:  sc_result_d = {{(WIDTH-1){1'b0}}, (op1 == op2)};
      OP_NE:  sc_result_d = {{(WIDTH-1){1'b0}}, (op1 != op2)};
      default: begin
        sc_result_d = '0;
        sc_err_d    = 1'b1;
      end
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_multicycle(alu_op)),
    .op     (alu_op_e'(alu_op)),
    .a      (op1),
    .b      (op2),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (is_multicycle(alu_op)) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
            end else
`endif
            begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= sc_result_d;
              err_q       <= sc_err_d;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          if (md_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_result;
            err_q       <= 1'b0;
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan sequences plus randomized traffic for
// alu_seq, checked every cycle against a scoreboard of expected results
// and ready times computed from the opcode definitions.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         alu_err;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .op1        (op1),
    .op2        (op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_err    (alu_err)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           rdy;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  bit           rst_seen = 1'b0;
  logic         lit_v;
  logic [W-1:0] lit_res;
  logic         lit_err;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: result, error flag and latency in cycles from the accept.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic e, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a << sh;
      4'd1:  r = a >> sh;
      4'd2:  r = W'($signed(a) >>> sh);
      4'd3:  r = a + b;
      4'd4:  r = a - b;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = a ^ b;
      4'd8:  r = W'($signed(a) < $signed(b));
      4'd9:  r = W'(a == b);
      4'd10: r = W'(a != b);
`ifdef ALU_SEQ_MULDIV_EN
      4'd11: begin r = W'(64'(a) * 64'(b)); lat = W + 1; end
      4'd12: begin r = (b == '0) ? '1 : a / b; lat = W + 1; end
      4'd13: begin r = (b == '0) ? a : a % b; lat = W + 1; end
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // Single compare process: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    logic         ev;
    logic         eir;
    logic [W-1:0] mr;
    logic         me;
    int           ml;
    cyc++;
    if (rst) begin
      q.delete();
      rst_seen = 1'b1;
    end else begin
      ev  = (q.size() > 0) && (cyc >= q[0].rdy);
      eir = (q.size() == 0) || (ev && out_ready);
      chk("out_valid", W'(out_valid), W'(ev));
      chk("in_ready", W'(in_ready), W'(eir));
      if (rst_seen) begin
        chk("reset_result", alu_result, '0);
        chk("reset_err", W'(alu_err), '0);
        rst_seen = 1'b0;
      end
      if (ev && out_valid) begin
        chk("alu_result", alu_result, q[0].res);
        chk("alu_err", W'(alu_err), W'(q[0].err));
      end
      if (ev && out_ready) begin
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        model(alu_op, op1, op2, mr, me, ml);
        if (lit_v) begin
          chk("model_pin_result", mr, lit_res);
          chk("model_pin_err", W'(me), W'(lit_err));
          mr = lit_res;
          me = lit_err;
        end
        q.push_back('{res: mr, err: me, rdy: cyc + ml});
      end
    end
  end

  // Present one op, hold until accepted (bounded), then scramble the inputs.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic lv, input logic [W-1:0] lr, input logic le);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    alu_op   = op;
    op1      = a;
    op2      = b;
    lit_v    = lv;
    lit_res  = lr;
    lit_err  = le;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout op %h: got in_ready low expected accept within 200 cycles", op);
    end
    in_valid = 1'b0;
    lit_v    = 1'b0;
    alu_op   = 4'($urandom);
    op1      = $urandom;
    op2      = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = '0;
    op1       = '0;
    op2       = '0;
    lit_v     = 1'b0;
    lit_res   = '0;
    lit_err   = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    send(4'b0011, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0);
    send(4'b0010, 32'h8000_0000, 32'h0000_0021, 1'b1, 32'hC000_0000, 1'b0);
`ifdef ALU_SEQ_MULDIV_EN
    send(4'b1011, 32'h0001_0003, 32'h0000_0010, 1'b1, 32'h0010_0030, 1'b0);
    send(4'b1100, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
    send(4'b1101, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0);
    send(4'b1100, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    send(4'b1101, 32'd9, 32'd0, 1'b1, 32'd9, 1'b0);
`else
    send(4'b1011, 32'h0001_0003, 32'h0000_0010, 1'b1, 32'd0, 1'b1);
    send(4'b1100, 32'd100, 32'd7, 1'b1, 32'd0, 1'b1);
    send(4'b1101, 32'd9, 32'd0, 1'b1, 32'd0, 1'b1);
`endif
    idle(2);

    // Back-pressure, then zero-bubble replacement of the held result.
    out_ready = 1'b0;
    send(4'b0100, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    idle(5);
    out_ready = 1'b1;
    send(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 32'hFF00_FF00, 1'b0);
    idle(2);

    send(4'b1111, 32'd1, 32'd2, 1'b1, 32'd0, 1'b1);
    send(4'b1110, 32'd3, 32'd4, 1'b1, 32'd0, 1'b1);
    idle(2);

    // Reset while a MUL is iterating: nothing may be emitted afterwards.
    send(4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, '0, 1'b0);
    idle(10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(40);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        alu_op   = 4'($urandom_range(0, 15));
        op1      = $urandom >> $urandom_range(0, 31);
        case ($urandom_range(0, 7))
          0:       op2 = '0;
          1, 2:    op2 = W'($urandom_range(0, 15));
          default: op2 = $urandom;
        endcase
      end
    end

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(45);
    chk("drain_empty", W'(q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
